rs_age_issue_queue: RTL and testbench
=====================================

Name: rs_age_issue_queue

Overview:
Parametrised next-generation reservation station for the out-of-order core. It sits between rename/dispatch and the execution units.
- Accepts up to ALLOC_W instructions per cycle.
- Captures operands from same-cycle CDB broadcasts.
- Selects the oldest ready entries by age matrix and issues them through registered, backpressured issue ports.
- Supports ROB-relative partial flush on mispredict.

Parameters:
RS_ENTRIES, 16, number of entries (power of two not required, >= ALLOC_W)
ALLOC_W, 2, allocation ports
ISSUE_W, 2, issue ports
CDB_W, 2, CDB broadcast ports
PHYS_W, 6, physical register tag width
ROB_W, 6, ROB tag width
DATA_W, 64, operand width
OP_W, 8, opcode width

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
alloc_valid  in  ALLOC_W  per-port allocate request
alloc_ready  out  1  all-or-nothing accept for the whole alloc group
alloc_dst_tag/alloc_src1_tag/alloc_src2_tag  in  ALLOC_W x PHYS_W  tags
alloc_src1_val/alloc_src2_val  in  ALLOC_W x DATA_W  operand values
alloc_src1_ready/alloc_src2_ready  in  ALLOC_W  operand valid at dispatch
alloc_op  in  ALLOC_W x OP_W  opcode
alloc_rob_tag  in  ALLOC_W x ROB_W  ROB tag
cdb_valid  in  CDB_W  broadcast valid
cdb_tag  in  CDB_W x PHYS_W  broadcast tag
cdb_value  in  CDB_W x DATA_W  broadcast value
issue_valid  out  ISSUE_W  issue register holds an instruction
issue_ready  in  ISSUE_W  FU accepts
issue_op/issue_dst_tag/issue_src1_val/issue_src2_val/issue_rob_tag  out  per port  issued fields
flush_valid  in  1  squash request
flush_rob_tag  in  ROB_W  youngest surviving ROB tag
rob_head  in  ROB_W  ROB head, used for relative age
free_count  out  $clog2(RS_ENTRIES+1)  registered count of free entries

Behaviour:
Reset:
- All entries invalid.
- Age matrix cleared.
- issue_valid=0 and all issue fields 0.
- free_count=RS_ENTRIES.
- alloc_ready=1.

Allocation:
- alloc_ready = !flush_valid && (free_count >= ALLOC_W).
- A port is accepted when alloc_valid[a] && alloc_ready.
- Ports fill the lowest-index free entries in port order.
- Within one cycle, a lower port is older than a higher port.
- New entry i is younger than all currently valid entries: set older[j][i]=1 for every valid j, and older[i][*]=0.

Wakeup:
- A CDB match in cycle t sets the operand ready and captures its value at edge t+1. This applies to resident entries and to entries being allocated in cycle t (same-cycle bypass on the alloc tag).
- If several CDB ports match the same tag, the highest CDB index wins.
- Values from a CDB match override alloc_src*_val.

Select:
- An entry is eligible if it is valid, both sources are ready, and it is not already claimed.
- Port p is refillable when !issue_valid[p] || issue_ready[p].
- Refillable ports, in ascending p, take the oldest remaining eligible entry: an entry with no eligible older[j][i]=1.
- On refill, the entry is copied into issue register p and invalidated at the same edge.
- If nothing is eligible, issue_valid[p] drops to 0 when the previous instruction was accepted.

Issue registers:
- Fields hold stable while issue_valid && !issue_ready.

Latency:
- Alloc handshake with ready operands in cycle t: issue_valid earliest in cycle t+2.
- CDB wakeup in cycle t: issue_valid earliest in cycle t+2.

Free entries:
- free_count updates every edge: previous value + entries freed (refill + flush) − entries allocated.

Flush:
- A resident entry or issue register is squashed when ((rob_tag − rob_head) mod 2^ROB_W) > ((flush_rob_tag − rob_head) mod 2^ROB_W).
- Flush takes priority over select for the same entry; no allocation is accepted in a flush cycle.
- Age-matrix rows and columns of squashed entries are cleared.

Boundary cases:
- Full: alloc_ready=0 and valid entries are retained.
- Free simultaneous with alloc in the same cycle: the freed slot is not reusable until the next cycle.
- All ports stalled: entries wait and ages are preserved.
- Reset mid-operation: immediate clear, asynchronous.

Optional Feature:
RS_PERF_CNT_EN:
- When defined, adds 32-bit outputs perf_issue_cnt (sum of issue handshakes per cycle), perf_full_cycles (cycles with free_count==0) and perf_flush_cnt.
- Counters saturate at all-ones and clear on reset.
- When undefined, these ports and counters do not exist.

Decomposition:
- core_pkg: ROB_W, PHYS_W, DATA_W defaults; opcode typedef; rob_age_cmp function (the relative-age compare).
- The entry struct is local to the module because it depends on parameters.
- One sub-module: rs_age_matrix_sel. It holds the age matrix update (alloc/free/flush) and the iterative oldest-of-eligible selection for ISSUE_W ports, returning one-hot grants.

Test Plan:
- Alloc 2 ops, both ready, tags ROB 3,4, at t0 -> issue_valid=2'b11 at t0+2; port0 rob 3, port1 rob 4; free_count returns to 16.
- Alloc with src1_ready=0 tag 9 while cdb_valid tag 9 value 0xDEAD in the same cycle -> entry issues at t+2 with src1_val=0xDEAD.
- Fill 16 entries -> alloc_ready=0, free_count=0; issue_ready=1 for one cycle -> free_count rises and alloc_ready=1 the next cycle.
- Issue port 0 stalled (issue_ready=0) for 5 cycles -> fields constant; port 1 continues issuing the next oldest entries.
- rob_head=60, entries with ROB 62,1,5, flush_rob_tag=1 -> only ROB 5 is squashed, including if it sits in an issue register; ROB 62 issues before ROB 1.
- Assert reset while 8 entries are valid and issue_valid=1 -> all outputs return to reset values immediately.

Source files
------------

// File: rtl/core_pkg.sv
// core_pkg: shared core default widths, opcode type and the ROB-relative age
// compare used by flush logic.
package core_pkg;

  localparam int ROB_W_DEF  = 6;
  localparam int PHYS_W_DEF = 6;
  localparam int DATA_W_DEF = 64;
  localparam int OP_W_DEF   = 8;

  typedef logic [OP_W_DEF-1:0] opcode_t;

  // True when tag is younger than flush_tag, both measured from head modulo 2^w.
  function automatic logic rob_age_cmp(input logic [31:0] tag,
                                       input logic [31:0] flush_tag,
                                       input logic [31:0] head,
                                       input int          w);
    logic [31:0] mask;
    mask = (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
    return ((tag - head) & mask) > ((flush_tag - head) & mask);
  endfunction

endpackage

// File: rtl/rs_age_matrix_sel.sv
// rs_age_matrix_sel: reservation-station age matrix (alloc/free/flush update)
// and iterative oldest-eligible select producing one-hot grants per issue port.
module rs_age_matrix_sel #(
  parameter int N       = 16,
  parameter int ALLOC_W = 2,
  parameter int ISSUE_W = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N-1:0]              valid,
  input  logic [N-1:0]              eligible,
  input  logic [N-1:0]              squash,
  input  logic [ALLOC_W-1:0][N-1:0] alloc_oh,
  input  logic [ISSUE_W-1:0]        refill,
  output logic [ISSUE_W-1:0][N-1:0] grant,
  output logic [N-1:0]              freed
);

  // older_reg[j][i] set means entry j is older than entry i.
  logic [N-1:0] older_reg  [N];
  logic [N-1:0] older_next [N];
  logic [N-1:0] col        [N];

  always_comb begin
    for (int i = 0; i < N; i++) begin
      col[i] = '0;
      for (int j = 0; j < N; j++) col[i][j] = older_reg[j][i];
    end
  end

  always_comb begin : select
    logic [N-1:0] cand;
    cand  = eligible;
    grant = '0;
    for (int p = 0; p < ISSUE_W; p++) begin
      for (int i = 0; i < N; i++)
        if (refill[p] && cand[i] && ((cand & col[i]) == '0))
          grant[p][i] = 1'b1;
      cand &= ~grant[p];
    end
  end

  always_comb begin
    freed = squash;
    for (int p = 0; p < ISSUE_W; p++) freed |= grant[p];
  end

  // New entries are younger than every surviving entry and than lower-port peers.
  always_comb begin
    for (int i = 0; i < N; i++) older_next[i] = older_reg[i];
    for (int i = 0; i < N; i++)
      if (freed[i]) begin
        older_next[i] = '0;
        for (int j = 0; j < N; j++) older_next[j][i] = 1'b0;
      end
    for (int a = 0; a < ALLOC_W; a++)
      for (int i = 0; i < N; i++)
        if (alloc_oh[a][i]) begin
          older_next[i] = '0;
          for (int j = 0; j < N; j++) older_next[j][i] = valid[j] && !freed[j];
          for (int b = 0; b < a; b++)
            for (int j = 0; j < N; j++)
              if (alloc_oh[b][j]) older_next[j][i] = 1'b1;
        end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N; i++) older_reg[i] <= '0;
    end else begin
      for (int i = 0; i < N; i++) older_reg[i] <= older_next[i];
    end
  end

endmodule

// File: rtl/rs_age_issue_queue.sv
// rs_age_issue_queue: age-ordered reservation station with CDB wakeup, registered
// backpressured issue ports and ROB-relative flush. RS_PERF_CNT_EN adds perf counters.
module rs_age_issue_queue
  import core_pkg::*;
#(
  parameter int RS_ENTRIES = 16,
  parameter int ALLOC_W    = 2,
  parameter int ISSUE_W    = 2,
  parameter int CDB_W      = 2,
  parameter int PHYS_W     = PHYS_W_DEF,
  parameter int ROB_W      = ROB_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int OP_W       = OP_W_DEF
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [ALLOC_W-1:0]                  alloc_valid,
  output logic                                alloc_ready,
  input  logic [ALLOC_W-1:0][PHYS_W-1:0]      alloc_dst_tag,
  input  logic [ALLOC_W-1:0][PHYS_W-1:0]      alloc_src1_tag,
  input  logic [ALLOC_W-1:0][PHYS_W-1:0]      alloc_src2_tag,
  input  logic [ALLOC_W-1:0][DATA_W-1:0]      alloc_src1_val,
  input  logic [ALLOC_W-1:0][DATA_W-1:0]      alloc_src2_val,
  input  logic [ALLOC_W-1:0]                  alloc_src1_ready,
  input  logic [ALLOC_W-1:0]                  alloc_src2_ready,
  input  logic [ALLOC_W-1:0][OP_W-1:0]        alloc_op,
  input  logic [ALLOC_W-1:0][ROB_W-1:0]       alloc_rob_tag,
  input  logic [CDB_W-1:0]                    cdb_valid,
  input  logic [CDB_W-1:0][PHYS_W-1:0]        cdb_tag,
  input  logic [CDB_W-1:0][DATA_W-1:0]        cdb_value,
  output logic [ISSUE_W-1:0]                  issue_valid,
  input  logic [ISSUE_W-1:0]                  issue_ready,
  output logic [ISSUE_W-1:0][OP_W-1:0]        issue_op,
  output logic [ISSUE_W-1:0][PHYS_W-1:0]      issue_dst_tag,
  output logic [ISSUE_W-1:0][DATA_W-1:0]      issue_src1_val,
  output logic [ISSUE_W-1:0][DATA_W-1:0]      issue_src2_val,
  output logic [ISSUE_W-1:0][ROB_W-1:0]       issue_rob_tag,
  input  logic                                flush_valid,
  input  logic [ROB_W-1:0]                    flush_rob_tag,
  input  logic [ROB_W-1:0]                    rob_head,
  output logic [$clog2(RS_ENTRIES+1)-1:0]     free_count
`ifdef RS_PERF_CNT_EN
  ,
  output logic [31:0]                         perf_issue_cnt,
  output logic [31:0]                         perf_full_cycles,
  output logic [31:0]                         perf_flush_cnt
`endif
);

  localparam int FC_W = $clog2(RS_ENTRIES+1);

  typedef struct packed {
    logic              valid;
    logic              s1_rdy;
    logic              s2_rdy;
    logic [PHYS_W-1:0] s1_tag;
    logic [PHYS_W-1:0] s2_tag;
    logic [PHYS_W-1:0] dst;
    logic [DATA_W-1:0] s1_val;
    logic [DATA_W-1:0] s2_val;
    logic [OP_W-1:0]   op;
    logic [ROB_W-1:0]  rob;
  } entry_t;

  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [PHYS_W-1:0] dst;
    logic [DATA_W-1:0] s1_val;
    logic [DATA_W-1:0] s2_val;
    logic [ROB_W-1:0]  rob;
  } issue_t;

  entry_t ent_reg [RS_ENTRIES];
  entry_t ent_next[RS_ENTRIES];
  entry_t new_ent [ALLOC_W];
  issue_t iss_reg [ISSUE_W];
  issue_t iss_next[ISSUE_W];
  logic [ISSUE_W-1:0] iss_valid_reg, iss_valid_next, iss_squash, refill;
  logic [FC_W-1:0] free_count_reg, free_count_next;
  logic [RS_ENTRIES-1:0] valid_vec, squash, eligible, freed, taken;
  logic [ALLOC_W-1:0][RS_ENTRIES-1:0] alloc_oh;
  logic [ISSUE_W-1:0][RS_ENTRIES-1:0] grant;

  // {hit, value}; the highest matching CDB port wins.
  function automatic logic [DATA_W:0] cdb_lookup(input logic [PHYS_W-1:0] tag,
      input logic [CDB_W-1:0] v, input logic [CDB_W-1:0][PHYS_W-1:0] t,
      input logic [CDB_W-1:0][DATA_W-1:0] d);
    logic [DATA_W:0] r;
    r = '0;
    for (int c = 0; c < CDB_W; c++)
      if (v[c] && t[c] == tag) r = {1'b1, d[c]};
    return r;
  endfunction

  assign alloc_ready = !flush_valid && (free_count_reg >= FC_W'(ALLOC_W));
  assign free_count  = free_count_reg;
  assign issue_valid = iss_valid_reg;

  for (genvar gi = 0; gi < RS_ENTRIES; gi++) begin : g_ent
    assign valid_vec[gi] = ent_reg[gi].valid;
    assign squash[gi]    = flush_valid && ent_reg[gi].valid &&
                           rob_age_cmp(32'(ent_reg[gi].rob), 32'(flush_rob_tag), 32'(rob_head), ROB_W);
    assign eligible[gi]  = ent_reg[gi].valid && ent_reg[gi].s1_rdy && ent_reg[gi].s2_rdy && !squash[gi];
  end

  for (genvar gi = 0; gi < ISSUE_W; gi++) begin : g_port
    assign refill[gi]     = !iss_valid_reg[gi] || issue_ready[gi];
    assign iss_squash[gi] = flush_valid && iss_valid_reg[gi] &&
                            rob_age_cmp(32'(iss_reg[gi].rob), 32'(flush_rob_tag), 32'(rob_head), ROB_W);
    assign issue_op[gi]       = iss_reg[gi].op;
    assign issue_dst_tag[gi]  = iss_reg[gi].dst;
    assign issue_src1_val[gi] = iss_reg[gi].s1_val;
    assign issue_src2_val[gi] = iss_reg[gi].s2_val;
    assign issue_rob_tag[gi]  = iss_reg[gi].rob;
  end

  rs_age_matrix_sel #(.N(RS_ENTRIES), .ALLOC_W(ALLOC_W), .ISSUE_W(ISSUE_W)) u_sel (
    .clk(clk), .reset(reset), .valid(valid_vec), .eligible(eligible), .squash(squash),
    .alloc_oh(alloc_oh), .refill(refill), .grant(grant), .freed(freed)
  );

  // Slots are picked from the registered valid bits, so a slot freed this cycle waits a cycle.
  always_comb begin : alloc_pick
    logic found;
    found    = 1'b0;
    taken    = '0;
    alloc_oh = '0;
    for (int a = 0; a < ALLOC_W; a++) begin
      found = 1'b0;
      if (alloc_valid[a] && alloc_ready)
        for (int i = 0; i < RS_ENTRIES; i++)
          if (!found && !ent_reg[i].valid && !taken[i]) begin
            alloc_oh[a][i] = 1'b1;
            taken[i]       = 1'b1;
            found          = 1'b1;
          end
    end
  end

  always_comb begin : alloc_build
    logic [DATA_W:0] h;
    h = '0;
    for (int a = 0; a < ALLOC_W; a++) begin
      new_ent[a]        = '0;
      new_ent[a].valid  = 1'b1;
      new_ent[a].s1_tag = alloc_src1_tag[a];
      new_ent[a].s2_tag = alloc_src2_tag[a];
      new_ent[a].dst    = alloc_dst_tag[a];
      new_ent[a].op     = alloc_op[a];
      new_ent[a].rob    = alloc_rob_tag[a];
      new_ent[a].s1_rdy = alloc_src1_ready[a];
      new_ent[a].s1_val = alloc_src1_val[a];
      new_ent[a].s2_rdy = alloc_src2_ready[a];
      new_ent[a].s2_val = alloc_src2_val[a];
      h = cdb_lookup(alloc_src1_tag[a], cdb_valid, cdb_tag, cdb_value);
      if (!alloc_src1_ready[a] && h[DATA_W]) begin
        new_ent[a].s1_rdy = 1'b1;
        new_ent[a].s1_val = h[DATA_W-1:0];
      end
      h = cdb_lookup(alloc_src2_tag[a], cdb_valid, cdb_tag, cdb_value);
      if (!alloc_src2_ready[a] && h[DATA_W]) begin
        new_ent[a].s2_rdy = 1'b1;
        new_ent[a].s2_val = h[DATA_W-1:0];
      end
    end
  end

  always_comb begin : ent_update
    logic [DATA_W:0] h;
    h = '0;
    for (int i = 0; i < RS_ENTRIES; i++) begin
      ent_next[i] = ent_reg[i];
      h = cdb_lookup(ent_reg[i].s1_tag, cdb_valid, cdb_tag, cdb_value);
      if (!ent_reg[i].s1_rdy && h[DATA_W]) begin
        ent_next[i].s1_rdy = 1'b1;
        ent_next[i].s1_val = h[DATA_W-1:0];
      end
      h = cdb_lookup(ent_reg[i].s2_tag, cdb_valid, cdb_tag, cdb_value);
      if (!ent_reg[i].s2_rdy && h[DATA_W]) begin
        ent_next[i].s2_rdy = 1'b1;
        ent_next[i].s2_val = h[DATA_W-1:0];
      end
      if (freed[i]) ent_next[i].valid = 1'b0;
      for (int a = 0; a < ALLOC_W; a++)
        if (alloc_oh[a][i]) ent_next[i] = new_ent[a];
    end
  end

  always_comb begin : iss_update
    for (int p = 0; p < ISSUE_W; p++) begin
      iss_next[p]       = iss_reg[p];
      iss_valid_next[p] = iss_valid_reg[p];
      if (grant[p] != '0) begin
        iss_valid_next[p] = 1'b1;
        for (int i = 0; i < RS_ENTRIES; i++)
          if (grant[p][i]) begin
            iss_next[p].op     = ent_reg[i].op;
            iss_next[p].dst    = ent_reg[i].dst;
            iss_next[p].s1_val = ent_reg[i].s1_val;
            iss_next[p].s2_val = ent_reg[i].s2_val;
            iss_next[p].rob    = ent_reg[i].rob;
          end
      end else if (refill[p] || iss_squash[p]) begin
        iss_valid_next[p] = 1'b0;
      end
    end
  end

  always_comb begin : fc_update
    logic [FC_W-1:0] n_freed, n_alloc;
    n_freed = '0;
    n_alloc = '0;
    for (int i = 0; i < RS_ENTRIES; i++) begin
      n_freed += FC_W'(freed[i]);
      n_alloc += FC_W'(taken[i]);
    end
    free_count_next = free_count_reg + n_freed - n_alloc;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < RS_ENTRIES; i++) ent_reg[i] <= '0;
      for (int p = 0; p < ISSUE_W; p++) iss_reg[p] <= '0;
      iss_valid_reg  <= '0;
      free_count_reg <= FC_W'(RS_ENTRIES);
    end else begin
      for (int i = 0; i < RS_ENTRIES; i++) ent_reg[i] <= ent_next[i];
      for (int p = 0; p < ISSUE_W; p++) iss_reg[p] <= iss_next[p];
      iss_valid_reg  <= iss_valid_next;
      free_count_reg <= free_count_next;
    end
  end

`ifdef RS_PERF_CNT_EN
  logic [31:0] perf_issue_reg, perf_full_reg, perf_flush_reg, n_hs;

  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] n);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, n};
    return s[32] ? '1 : s[31:0];
  endfunction

  always_comb begin
    n_hs = '0;
    for (int p = 0; p < ISSUE_W; p++) n_hs += 32'(iss_valid_reg[p] && issue_ready[p]);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_issue_reg <= '0;
      perf_full_reg  <= '0;
      perf_flush_reg <= '0;
    end else begin
      perf_issue_reg <= sat_add(perf_issue_reg, n_hs);
      perf_full_reg  <= sat_add(perf_full_reg, 32'(free_count_reg == '0));
      perf_flush_reg <= sat_add(perf_flush_reg, 32'(flush_valid));
    end
  end

  assign perf_issue_cnt   = perf_issue_reg;
  assign perf_full_cycles = perf_full_reg;
  assign perf_flush_cnt   = perf_flush_reg;
`endif

endmodule

// File: tb/tb_rs_age_issue_queue.sv
// tb_rs_age_issue_queue: directed vectors with hand-computed expectations for
// allocation, bypass wakeup, age order, backpressure, flush and async reset.
module tb_rs_age_issue_queue;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset;
  logic [1:0]        alloc_valid;
  logic              alloc_ready;
  logic [1:0][5:0]   alloc_dst_tag, alloc_src1_tag, alloc_src2_tag;
  logic [1:0][63:0]  alloc_src1_val, alloc_src2_val;
  logic [1:0]        alloc_src1_ready, alloc_src2_ready;
  logic [1:0][7:0]   alloc_op;
  logic [1:0][5:0]   alloc_rob_tag;
  logic [1:0]        cdb_valid;
  logic [1:0][5:0]   cdb_tag;
  logic [1:0][63:0]  cdb_value;
  logic [1:0]        issue_valid, issue_ready;
  logic [1:0][7:0]   issue_op;
  logic [1:0][5:0]   issue_dst_tag;
  logic [1:0][63:0]  issue_src1_val, issue_src2_val;
  logic [1:0][5:0]   issue_rob_tag;
  logic              flush_valid;
  logic [5:0]        flush_rob_tag, rob_head;
  logic [4:0]        free_count;
`ifdef RS_PERF_CNT_EN
  logic [31:0]       perf_issue_cnt, perf_full_cycles, perf_flush_cnt;
`endif

  int total = 0;
  int bad   = 0;

  rs_age_issue_queue dut (
    .clk(clk), .reset(reset),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready),
    .alloc_dst_tag(alloc_dst_tag), .alloc_src1_tag(alloc_src1_tag), .alloc_src2_tag(alloc_src2_tag),
    .alloc_src1_val(alloc_src1_val), .alloc_src2_val(alloc_src2_val),
    .alloc_src1_ready(alloc_src1_ready), .alloc_src2_ready(alloc_src2_ready),
    .alloc_op(alloc_op), .alloc_rob_tag(alloc_rob_tag),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_op(issue_op), .issue_dst_tag(issue_dst_tag),
    .issue_src1_val(issue_src1_val), .issue_src2_val(issue_src2_val),
    .issue_rob_tag(issue_rob_tag),
    .flush_valid(flush_valid), .flush_rob_tag(flush_rob_tag), .rob_head(rob_head),
    .free_count(free_count)
`ifdef RS_PERF_CNT_EN
    , .perf_issue_cnt(perf_issue_cnt), .perf_full_cycles(perf_full_cycles),
    .perf_flush_cnt(perf_flush_cnt)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_alloc();
    alloc_valid      = '0;
    alloc_src1_ready = '0;
    alloc_src2_ready = '0;
    alloc_dst_tag    = '0;
    alloc_src1_tag   = '0;
    alloc_src2_tag   = '0;
    alloc_src1_val   = '0;
    alloc_src2_val   = '0;
    alloc_op         = '0;
    alloc_rob_tag    = '0;
  endtask

  // Values derive from the ROB tag: src1=0x100+rob, src2=0x200+rob, dst=rob, op={2'b10,rob}.
  task automatic put(input int a, input logic [5:0] rob, input logic r1, input logic [5:0] t1,
                     input logic r2, input logic [5:0] t2);
    alloc_valid[a]      = 1'b1;
    alloc_rob_tag[a]    = rob;
    alloc_dst_tag[a]    = rob;
    alloc_op[a]         = {2'b10, rob};
    alloc_src1_ready[a] = r1;
    alloc_src1_tag[a]   = t1;
    alloc_src2_ready[a] = r2;
    alloc_src2_tag[a]   = t2;
    alloc_src1_val[a]   = 64'h100 + 64'(rob);
    alloc_src2_val[a]   = 64'h200 + 64'(rob);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    clear_alloc();
    cdb_valid = '0; cdb_tag = '0; cdb_value = '0;
    issue_ready = '0; flush_valid = 1'b0; flush_rob_tag = '0; rob_head = '0;
    #1 reset = 1'b1;
    #1;
    check("rst_issue_valid", 64'(issue_valid), 64'd0);
    check("rst_free", 64'(free_count), 64'd16);
    check("rst_alloc_ready", 64'(alloc_ready), 64'd1);
    check("rst_rob0", 64'(issue_rob_tag[0]), 64'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    issue_ready = 2'b11;
    tick();

    // Two ready ops: issue at t0+2, oldest on port 0.
    put(0, 6'd3, 1'b1, 6'd0, 1'b1, 6'd0);
    put(1, 6'd4, 1'b1, 6'd0, 1'b1, 6'd0);
    #1 check("t1_alloc_ready", 64'(alloc_ready), 64'd1);
    tick(); clear_alloc();
    check("t1_mid_valid", 64'(issue_valid), 64'd0);
    check("t1_mid_free", 64'(free_count), 64'd14);
    tick();
    check("t1_valid", 64'(issue_valid), 64'd3);
    check("t1_rob0", 64'(issue_rob_tag[0]), 64'd3);
    check("t1_rob1", 64'(issue_rob_tag[1]), 64'd4);
    check("t1_src1_0", issue_src1_val[0], 64'h103);
    check("t1_op1", 64'(issue_op[1]), 64'h84);
    check("t1_free", 64'(free_count), 64'd16);
    tick();
    check("t1_drop", 64'(issue_valid), 64'd0);

    // Same-cycle CDB bypass on allocation.
    put(0, 6'd8, 1'b0, 6'd9, 1'b1, 6'd0);
    cdb_valid = 2'b01; cdb_tag[0] = 6'd9; cdb_value[0] = 64'hDEAD;
    tick(); clear_alloc(); cdb_valid = '0;
    tick();
    check("byp_valid", 64'(issue_valid), 64'd1);
    check("byp_src1", issue_src1_val[0], 64'hDEAD);
    check("byp_src2", issue_src2_val[0], 64'h208);

    // Resident wakeup, both CDB ports hit the same tag: port 1 value wins.
    put(0, 6'd9, 1'b1, 6'd0, 1'b0, 6'd12);
    tick(); clear_alloc();
    cdb_valid = 2'b11; cdb_tag[0] = 6'd12; cdb_tag[1] = 6'd12;
    cdb_value[0] = 64'h1111; cdb_value[1] = 64'h2222;
    tick(); cdb_valid = '0;
    check("wake_early", 64'(issue_valid), 64'd0);
    tick();
    check("wake_valid", 64'(issue_valid), 64'd1);
    check("wake_src2", issue_src2_val[0], 64'h2222);
    check("wake_src1", issue_src1_val[0], 64'h109);
    tick();
    issue_ready = 2'b00;

    // Fill all 16 entries with operands waiting on tag 20.
    for (int k = 0; k < 8; k++) begin
      check("fill_free", 64'(free_count), 64'(16 - 2 * k));
      put(0, 6'(10 + 2 * k), 1'b0, 6'd20, 1'b1, 6'd0);
      put(1, 6'(11 + 2 * k), 1'b0, 6'd20, 1'b1, 6'd0);
      tick();
    end
    clear_alloc();
    #1;
    check("full_free", 64'(free_count), 64'd0);
    check("full_ready", 64'(alloc_ready), 64'd0);
    put(0, 6'd40, 1'b1, 6'd0, 1'b1, 6'd0);
    put(1, 6'd41, 1'b1, 6'd0, 1'b1, 6'd0);
    cdb_valid = 2'b01; cdb_tag[0] = 6'd20; cdb_value[0] = 64'h77;
    tick(); clear_alloc(); cdb_valid = '0;
    check("full_hold_free", 64'(free_count), 64'd0);
    tick();
    check("full_iss_valid", 64'(issue_valid), 64'd3);
    check("full_rob0", 64'(issue_rob_tag[0]), 64'd10);
    check("full_rob1", 64'(issue_rob_tag[1]), 64'd11);
    check("full_src1", issue_src1_val[0], 64'h77);
    check("full_free2", 64'(free_count), 64'd2);
    check("full_ready2", 64'(alloc_ready), 64'd1);

    // Port 0 stalled: held fields; port 1 keeps taking the next oldest.
    issue_ready = 2'b10;
    for (int j = 1; j <= 5; j++) begin
      tick();
      check("stall_rob0", 64'(issue_rob_tag[0]), 64'd10);
      check("stall_dst0", 64'(issue_dst_tag[0]), 64'd10);
      check("stall_rob1", 64'(issue_rob_tag[1]), 64'(11 + j));
      check("stall_free", 64'(free_count), 64'(2 + j));
    end

    issue_ready = 2'b11;
    begin
      int n;
      n = 0;
      while (!(free_count == 5'd16 && issue_valid == 2'b00) && n < 60) begin
        tick();
        n++;
      end
    end
    check("drain_free", 64'(free_count), 64'd16);
    check("drain_valid", 64'(issue_valid), 64'd0);

    // Flush relative to rob_head=60, keep ROB<=1: ROB 5 (in issue reg) and ROB 7 die.
    rob_head = 6'd60;
    issue_ready = 2'b00;
    put(0, 6'd5, 1'b1, 6'd0, 1'b1, 6'd0);
    tick(); clear_alloc();
    put(0, 6'd62, 1'b0, 6'd30, 1'b1, 6'd0);
    put(1, 6'd1, 1'b0, 6'd30, 1'b1, 6'd0);
    tick(); clear_alloc();
    check("fl_iss_valid", 64'(issue_valid), 64'd1);
    check("fl_iss_rob", 64'(issue_rob_tag[0]), 64'd5);
    check("fl_free_a", 64'(free_count), 64'd14);
    put(0, 6'd7, 1'b0, 6'd30, 1'b1, 6'd0);
    tick(); clear_alloc();
    check("fl_free_b", 64'(free_count), 64'd13);
    flush_valid = 1'b1; flush_rob_tag = 6'd1;
    put(0, 6'd2, 1'b1, 6'd0, 1'b1, 6'd0);
    #1 check("fl_alloc_ready", 64'(alloc_ready), 64'd0);
    tick(); clear_alloc(); flush_valid = 1'b0;
    check("fl_sq_valid", 64'(issue_valid), 64'd0);
    check("fl_free_c", 64'(free_count), 64'd14);
    cdb_valid = 2'b10; cdb_tag[1] = 6'd30; cdb_value[1] = 64'h30;
    tick(); cdb_valid = '0;
    tick();
    check("fl_post_valid", 64'(issue_valid), 64'd3);
    check("fl_post_rob0", 64'(issue_rob_tag[0]), 64'd62);
    check("fl_post_rob1", 64'(issue_rob_tag[1]), 64'd1);
    check("fl_post_free", 64'(free_count), 64'd16);
    issue_ready = 2'b11;
    tick();
    check("fl_none_left", 64'(issue_valid), 64'd0);

    // Asynchronous reset with 8 resident entries and a live issue register.
    rob_head = 6'd0;
    issue_ready = 2'b00;
    for (int k = 0; k < 4; k++) begin
      put(0, 6'(40 + 2 * k), 1'b0, 6'd40, 1'b1, 6'd0);
      put(1, 6'(41 + 2 * k), 1'b0, 6'd40, 1'b1, 6'd0);
      tick();
    end
    clear_alloc();
    put(0, 6'd50, 1'b1, 6'd0, 1'b1, 6'd0);
    tick(); clear_alloc();
    tick();
    check("pre_rst_valid", 64'(issue_valid), 64'd1);
    check("pre_rst_free", 64'(free_count), 64'd8);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_valid", 64'(issue_valid), 64'd0);
    check("mid_rst_free", 64'(free_count), 64'd16);
    check("mid_rst_ready", 64'(alloc_ready), 64'd1);
    check("mid_rst_rob0", 64'(issue_rob_tag[0]), 64'd0);
    check("mid_rst_src1", issue_src1_val[0], 64'd0);
    tick();
    reset = 1'b0;
    tick();
    check("post_rst_free", 64'(free_count), 64'd16);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
